// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, ALUOp codes,
// opcode constants and datapath mux selects.
package mips_ctrl_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned ALUOP_W  = 3;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned MUXSEL_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_I_EXEC   = 4'd11,
    S_I_WB     = 4'd12
  } state_t;

  // ALUOp codes, also consumed by AluControl
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 3'b001;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b010;
  localparam logic [ALUOP_W-1:0] ALUOP_OR    = 3'b011;
  localparam logic [ALUOP_W-1:0] ALUOP_AND   = 3'b100;
  localparam logic [ALUOP_W-1:0] ALUOP_SLT   = 3'b101;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'd0;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'd2;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'd4;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'd8;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'd10;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'd12;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'd13;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'd35;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'd43;

  localparam logic [MUXSEL_W-1:0] SRCB_REG     = 2'b00;
  localparam logic [MUXSEL_W-1:0] SRCB_FOUR    = 2'b01;
  localparam logic [MUXSEL_W-1:0] SRCB_IMM     = 2'b10;
  localparam logic [MUXSEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [MUXSEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [MUXSEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [MUXSEL_W-1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_itype(input logic [OPCODE_W-1:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
  endfunction

endpackage

// File: rtl/multicycle_main_control_imm_aluop_decode.sv
// Maps an I-type ALU opcode to the ALUOp code driven during immediate execute.
module imm_aluop_decode
  import mips_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output logic [ALUOP_W-1:0]  alu_op_c
);

  always_comb begin
    alu_op_c = ALUOP_ADD;
    case (opcode)
      OP_ANDI: alu_op_c = ALUOP_AND;
      OP_ORI:  alu_op_c = ALUOP_OR;
      OP_SLTI: alu_op_c = ALUOP_SLT;
      default: alu_op_c = ALUOP_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle MIPS datapath: fetch/decode/execute/memory/
// writeback sequencing with Moore outputs plus Mealy strobes on the memory handshake.
module multicycle_main_control
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mdr_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [MUXSEL_W-1:0] alu_src_b,
  output logic [MUXSEL_W-1:0] pc_source,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                illegal_op,
  output logic [STATE_W-1:0]  state_dbg
);

  state_t             state, state_next;
  logic               mem_rdy;
  logic [ALUOP_W-1:0] imm_alu_op;
  logic               unused_zero;

  // The beq PC gating on zero lives outside this block
  assign unused_zero = zero;
  assign mem_rdy     = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign state_dbg   = state;

  imm_aluop_decode u_imm_aluop_decode (
    .opcode   (opcode),
    .alu_op_c (imm_alu_op)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RESET;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    pc_source     = PCSRC_ALU;
    alu_op        = ALUOP_ADD;
    illegal_op    = 1'b0;

    case (state)
      S_RESET: state_next = S_FETCH;

      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_rdy) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end

      // Branch target is computed speculatively into ALUOut while decoding
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        if (opcode == OP_RTYPE)                        state_next = S_R_EXEC;
        else if (opcode == OP_LW || opcode == OP_SW)   state_next = S_MEM_ADDR;
        else if (opcode == OP_BEQ)                     state_next = S_BRANCH;
        else if (opcode == OP_J)                       state_next = S_JUMP;
        else if (is_itype(opcode))                     state_next = S_I_EXEC;
        else begin
          illegal_op = 1'b1;
          state_next = S_FETCH;
        end
      end

      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_rdy) begin
          mdr_write  = 1'b1;
          state_next = S_MEM_WB;
        end
      end

      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end

      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_rdy) state_next = S_FETCH;
      end

      S_R_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_RTYPE;
        state_next = S_R_WB;
      end

      S_R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        state_next    = S_FETCH;
      end

      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        state_next = S_FETCH;
      end

      S_I_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_op     = imm_alu_op;
        state_next = S_I_WB;
      end

      S_I_WB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end

      default: state_next = S_FETCH;
    endcase
  end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback for each instruction.
- Drives the 3-bit ALUOp consumed by AluControl, plus all datapath mux, enable and memory strobes.
- Stalls on a memory-ready handshake. Sits between the instruction register opcode field and the shared ALU/memory/register-file datapath.

Parameters:
- MEM_WAIT_EN, 1, 1 = honour mem_ready; 0 = treat memory as single-cycle (mem_ready ignored, taken as 1).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26] of the current instruction
- zero  in  1  ALU zero flag (for beq)
- mem_ready  in  1  memory has completed the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero=1
- iord  out  1  memory address source: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- mdr_write  out  1  memory data register load
- mem_to_reg  out  1  register-file write data: 0 = ALUOut, 1 = MDR
- reg_dst  out  1  destination register: 0 = rt, 1 = rd
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU B input: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm << 2
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_op  out  3  AluControl opcode
- illegal_op  out  1  one-cycle pulse on unknown opcode
- state_dbg  out  4  current state encoding

Behaviour:
- ALUOp encoding (fixed, shared with AluControl):
  - 000 add
  - 001 R-type (decode func)
  - 010 sub
  - 011 or
  - 100 and
  - 101 slt
- States:
  - S_RESET=0, S_FETCH=1, S_DECODE=2, S_MEM_ADDR=3, S_MEM_RD=4, S_MEM_WB=5, S_MEM_WR=6
  - S_R_EXEC=7, S_R_WB=8, S_BRANCH=9, S_JUMP=10, S_I_EXEC=11, S_I_WB=12
- Reset:
  - state = S_RESET.
  - All outputs 0, including alu_op=000 and illegal_op=0.
  - S_RESET → S_FETCH unconditionally on the next edge.
  - Reset assertion mid-instruction aborts immediately; no partial write strobe survives the cycle in which rst_n falls.
- Output style:
  - Outputs are combinational from state, except where marked Mealy.
  - All outputs not listed for a state are 0.
- S_FETCH:
  - iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00.
  - Mealy: ir_write=1 and pc_write=1 only in the cycle mem_ready=1; that same cycle → S_DECODE. Otherwise hold in S_FETCH.
- S_DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALUOut).
  - Next state by opcode:
    - 0 → S_R_EXEC
    - 35 (lw) or 43 (sw) → S_MEM_ADDR
    - 4 (beq) → S_BRANCH
    - 2 (j) → S_JUMP
    - 8 (addi), 12 (andi), 13 (ori), 10 (slti) → S_I_EXEC
    - other → S_FETCH with illegal_op=1 for this cycle only (Mealy).
- S_MEM_ADDR:
  - alu_src_a=1, alu_src_b=10, alu_op=000.
  - → S_MEM_RD if opcode=35, else S_MEM_WR.
- S_MEM_RD:
  - iord=1, mem_read=1.
  - Mealy: mdr_write=1 when mem_ready; then → S_MEM_WB. Otherwise hold.
- S_MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1 → S_FETCH.
- S_MEM_WR:
  - iord=1, mem_write=1, held high while waiting.
  - → S_FETCH when mem_ready; otherwise hold.
- S_R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=001 → S_R_WB.
- S_R_WB: reg_dst=1, mem_to_reg=0, reg_write=1 → S_FETCH.
- S_BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=010, pc_write_cond=1, pc_source=01 → S_FETCH.
  - The PC loads only if zero=1; that gating is external.
- S_JUMP: pc_write=1, pc_source=10 → S_FETCH.
- S_I_EXEC:
  - alu_src_a=1, alu_src_b=10.
  - alu_op: addi=000, andi=100, ori=011, slti=101.
  - → S_I_WB.
- S_I_WB: reg_dst=0, mem_to_reg=0, reg_write=1 → S_FETCH.
- Latency (cycles, with mem_ready always 1):
  - R-type 4, lw 5, sw 4, beq 3, j 3, I-type 4.
  - Each wait cycle (mem_ready=0) adds 1.
- opcode is sampled only in S_DECODE, S_MEM_ADDR and S_I_EXEC; the IR holds it stable from S_DECODE onward.
- Never assert mem_read and mem_write together. Never assert reg_write in the same cycle as mem_read.
- state_dbg equals the state encoding above.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state encodings
  - ALUOp codes
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI)
  - alu_src_b and pc_source mux codes
- AluControl is expected to import the same ALUOp codes.
- One sub-module: imm_aluop_decode, mapping an I-type opcode to alu_op. Purely combinational; used in S_I_EXEC.

Test Plan:
- Reset then R-type (opcode=0), mem_ready=1 → states 0,1,2,7,8,1.
  - alu_op=001 in S_R_EXEC.
  - reg_write=1 and reg_dst=1 in exactly one cycle.
- lw (opcode=35), mem_ready low for 2 cycles in FETCH and 3 in MEM_RD.
  - ir_write/pc_write pulse once, on the ready cycle.
  - mdr_write pulses once.
  - Total 10 cycles, FETCH to the next FETCH.
- beq (opcode=4), zero=1 then a repeat with zero=0.
  - Both: alu_op=010, pc_write_cond=1, pc_source=01 in S_BRANCH.
  - Both: back in S_FETCH after 3 cycles.
- slti (opcode=10) → alu_op=101 in S_I_EXEC; reg_dst=0 in S_I_WB.
- Illegal opcode (opcode=63) → illegal_op high for exactly 1 cycle in S_DECODE; next state S_FETCH; no reg_write and no mem_write asserted.
- sw with mem_ready=0, rst_n dropped while in S_MEM_WR → mem_write falls to 0 asynchronously, state_dbg=0, then S_FETCH after rst_n rises.
